// File: rtl/mario_pkg.sv
// Shared definitions for the Mario colour mixer: the palette address layout,
// the RGB slice layout and the default download region.
package mario_pkg;

  localparam logic [8:0] PAL_BASE_DEF = 9'h1F0;
  localparam int         PAL_AW       = 8;
  localparam int         PAL_DW       = 8;

  // Palette address, MSB first: {bank, src, col[3:0], vid[1:0]}
  typedef struct packed {
    logic       bank;
    logic       src;
    logic [3:0] col;
    logic [1:0] vid;
  } pal_addr_t;

  // Palette byte layout: R = [7:5], G = [4:2], B = [1:0]
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;

  function automatic rgb_t pal_to_rgb(input logic [PAL_DW-1:0] d, input logic inv);
    logic [PAL_DW-1:0] v;
    v = inv ? ~d : d;
    return rgb_t'(v);
  endfunction

endpackage

// File: rtl/mario_pal_ram.sv
// 256x8 palette RAM: one write port, one registered read port.
// The read is read-first, so a write to the address being read shows up on the following read.
module mario_pal_ram
  import mario_pkg::*;
(
  input  logic              I_CLK_24M,
  input  logic              I_WE,
  input  logic [PAL_AW-1:0] I_WADDR,
  input  logic [PAL_DW-1:0] I_WDATA,
  input  logic [PAL_AW-1:0] I_RADDR,
  output logic [PAL_DW-1:0] O_RDATA
);

  logic [PAL_DW-1:0] mem [2**PAL_AW];

  always_ff @(posedge I_CLK_24M) begin
    if (I_WE) begin
      mem[I_WADDR] <= I_WDATA;
    end
    O_RDATA <= mem[I_RADDR];
  end

endmodule

// File: rtl/mario_col_mix.sv
// Sprite/background priority mixer with a palette lookup. There are two pixel stages, both
// clocked by a strobe taken from the rising edge of I_H_CNT[0].
module mario_col_mix
  import mario_pkg::*;
#(
  parameter logic [8:0] PAL_BASE   = PAL_BASE_DEF,
  parameter bit         INVERT_OUT = 1'b1
) (
  input  logic        I_CLK_24M,
  input  logic        I_RESETn,
  input  logic [9:0]  I_H_CNT,
  input  logic [3:0]  I_BG_COL,
  input  logic [1:0]  I_BG_VID,
  input  logic [3:0]  I_OBJ_COL,
  input  logic [1:0]  I_OBJ_VID,
  input  logic        I_PALBANK,
  input  logic        I_CMPBLK,
  input  logic        I_HBLANK,
  input  logic        I_VBLANK,
  input  logic [16:0] I_DLADDR,
  input  logic [7:0]  I_DLDATA,
  input  logic        I_DLWR,
  output logic [2:0]  O_R,
  output logic [2:0]  O_G,
  output logic [1:0]  O_B,
  output logic        O_HBLANK,
  output logic        O_VBLANK
);

  logic        h0_q;
  logic        pix_ce;
  pal_addr_t   sel_addr;
  pal_addr_t   s1_addr;
  logic        s1_blank;
  logic        s1_hb;
  logic        s1_vb;
  logic [7:0]  pal_q;
  rgb_t        rgb;
  logic        pal_we;
  logic        unused_hcnt;

  assign unused_hcnt = ^I_H_CNT[9:1];

  // pix_ce is a single-cycle advance with no backpressure. Every pipeline register moves
  // only when it is high, and it is high on the cycle after I_H_CNT[0] is sampled going from 0 to 1.
  always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      h0_q   <= 1'b0;
      pix_ce <= 1'b0;
    end else begin
      h0_q   <= I_H_CNT[0];
      pix_ce <= I_H_CNT[0] & ~h0_q;
    end
  end

  // A nonzero sprite pixel wins. Otherwise the background is used, even when it is transparent.
  always_comb begin
    sel_addr      = '0;
    sel_addr.bank = I_PALBANK;
    if (I_OBJ_VID != 2'd0) begin
      sel_addr.src = 1'b1;
      sel_addr.col = I_OBJ_COL;
      sel_addr.vid = I_OBJ_VID;
    end else begin
      sel_addr.src = 1'b0;
      sel_addr.col = I_BG_COL;
      sel_addr.vid = I_BG_VID;
    end
  end

  assign pal_we = I_DLWR && (I_DLADDR[16:8] == PAL_BASE);

  mario_pal_ram u_pal (
    .I_CLK_24M (I_CLK_24M),
    .I_WE      (pal_we),
    .I_WADDR   (I_DLADDR[7:0]),
    .I_WDATA   (I_DLDATA),
    .I_RADDR   (s1_addr),
    .O_RDATA   (pal_q)
  );

  assign rgb = pal_to_rgb(pal_q, INVERT_OUT);

  always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      s1_addr  <= '0;
      s1_blank <= 1'b1;
      s1_hb    <= 1'b1;
      s1_vb    <= 1'b1;
      O_R      <= '0;
      O_G      <= '0;
      O_B      <= '0;
      O_HBLANK <= 1'b1;
      O_VBLANK <= 1'b1;
    end else if (pix_ce) begin
      s1_addr  <= sel_addr;
      s1_blank <= I_CMPBLK;
      s1_hb    <= I_HBLANK;
      s1_vb    <= I_VBLANK;
      O_R      <= s1_blank ? 3'd0 : rgb.r;
      O_G      <= s1_blank ? 3'd0 : rgb.g;
      O_B      <= s1_blank ? 2'd0 : rgb.b;
      O_HBLANK <= s1_hb;
      O_VBLANK <= s1_vb;
    end
  end

endmodule

// File: doc/mario_col_mix.md
MARIO_COL_MIX -- requirements
Module: mario_col_mix

Interface
REQ-001 Parameter PAL_BASE, 9'h1F0, download address bits [16:8] that select the palette region.
REQ-002 Parameter INVERT_OUT, 1, when 1 palette data is inverted before output (active-low PROM contents).
REQ-003 I_CLK_24M  in  1  sole clock, all logic on rising edge.
REQ-004 I_RESETn  in  1  asynchronous active-low reset.
REQ-005 I_H_CNT  in  10  horizontal counter; bit 0 rising edge defines the pixel strobe.
REQ-006 I_BG_COL  in  4  background tile colour from the tile stage.
REQ-007 I_BG_VID  in  2  background pixel bits.
REQ-008 I_OBJ_COL  in  4  sprite colour.
REQ-009 I_OBJ_VID  in  2  sprite pixel bits.
REQ-010 I_PALBANK  in  1  CPU palette bank latch.
REQ-011 I_CMPBLK  in  1  composite blank, high = blank.
REQ-012 I_HBLANK, I_VBLANK  in  1 each  raw blanking for sync alignment.
REQ-013 I_DLADDR  in  17 / I_DLDATA  in  8 / I_DLWR  in  1  ROM download port, synchronous to I_CLK_24M.
REQ-014 O_R  out  3 / O_G  out  3 / O_B  out  2  registered pixel colour.
REQ-015 O_HBLANK, O_VBLANK  out  1 each  blanking delayed to match the pixel pipeline.

Function
REQ-016 The block SHALL derive PIX_CE as a one-clock pulse on the I_CLK_24M cycle after I_H_CNT[0] is sampled rising (previous 0, current 1).
REQ-017 Priority: when I_OBJ_VID != 0, the sprite SHALL be selected (SRC=1, COL=I_OBJ_COL, VID=I_OBJ_VID); otherwise the background SHALL be selected (SRC=0, COL=I_BG_COL, VID=I_BG_VID), including when I_BG_VID=0.
REQ-018 Stage 1 (on PIX_CE): register palette address {I_PALBANK, SRC, COL[3:0], VID[1:0]} (8 bits) together with I_CMPBLK, I_HBLANK and I_VBLANK.
REQ-019 Palette: 256x8 synchronous RAM, read every clock at the stage-1 address, read data valid one clock later.
REQ-020 Stage 2 (on the next PIX_CE): register RGB = data[7:5]->O_R, [4:2]->O_G, [1:0]->O_B, inverted when INVERT_OUT=1; register the stage-1 blanks into O_HBLANK/O_VBLANK.
REQ-021 If the stage-1 blank is 1, stage 2 SHALL force O_R=O_G=O_B=0 regardless of palette data.
REQ-022 Latency: inputs sampled at strobe N SHALL appear on the outputs at strobe N+1; outputs SHALL hold between strobes.
REQ-023 Palette write: when I_DLWR=1 and I_DLADDR[16:8]==PAL_BASE, write I_DLDATA at I_DLADDR[7:0] in the same clock; other addresses SHALL be ignored.
REQ-024 A simultaneous read and write of the same entry SHALL return the old data (read-first); the new data SHALL be visible from the next read.
REQ-025 If I_H_CNT[0] stays constant, no pipeline register SHALL change.

Reset
REQ-026 While I_RESETn=0: O_R/O_G/O_B=0, O_HBLANK=O_VBLANK=1, stage-1 address=0, stage-1 blanks=1, edge-detect history=0.
REQ-027 Palette contents SHALL NOT be cleared by reset; a reset asserted mid-line SHALL take effect immediately (asynchronously); the first PIX_CE after release follows REQ-016.

Structure
REQ-028 The palette-address field layout, output bit slices and PAL_BASE default SHALL live in a shared package, mario_pkg.
REQ-029 The palette RAM SHALL be one sub-module, mario_pal_ram (256x8, one write port, one synchronous read port).

Verification
REQ-030 Download 8'hE3 to addr {PAL_BASE,8'h05}; INVERT_OUT=0; BG_COL=1, BG_VID=1, OBJ_VID=0, PALBANK=0, CMPBLK=0 -> after two strobes O_R=7, O_G=0, O_B=3.
REQ-031 Same setup with OBJ_VID=2, OBJ_COL=4 -> address 8'h52 selected; preloaded 8'h1C yields O_R=0, O_G=7, O_B=0.
REQ-032 CMPBLK=1 at strobe N with nonzero palette data -> at strobe N+1 RGB=0; HBLANK pulse delayed by exactly one strobe.
REQ-033 Download write with I_DLADDR[16:8]!=PAL_BASE -> palette unchanged, outputs identical to before.
REQ-034 Assert I_RESETn=0 mid-line -> outputs immediately 0/blank=1; after release, first valid pixel appears at the second strobe.
REQ-035 Hold I_H_CNT[0] constant for 20 clocks with changing inputs -> outputs do not change.
